// File: rtl/lsu_dpram_adapter.sv
// lsu_dpram_adapter: one-outstanding core load/store (t_req/i_rsp) to 32-bit byte-masked RAM port (i_mem/t_mem) bridge
module lsu_dpram_adapter #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rstf,
  input  logic              t_req_valid,
  output logic              t_req_ready,
  input  logic              t_req_we,
  input  logic [31:0]       t_req_addr,
  input  logic [1:0]        t_req_size,
  input  logic              t_req_unsigned,
  input  logic [31:0]       t_req_wdata,
  output logic              i_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       i_rsp_data,
  output logic              i_rsp_err,
  output logic              i_mem_valid,
  input  logic              i_mem_ready,
  output logic              i_mem_we,
  output logic [ADDR_W-1:0] i_mem_addr,
  output logic [31:0]       i_mem_data,
  output logic [3:0]        i_mem_mask,
  input  logic              t_mem_valid,
  input  logic [31:0]       t_mem_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;
  state_t state, state_nx;
  logic live, we, uns, err, bad, acc, iss, st;
  logic [ADDR_W-1:0] addr;
  logic [1:0] size;
  logic [31:0] wdata, rdata, sh, ext;
  assign acc = t_req_valid & t_req_ready;
  assign bad = (&t_req_size) | (t_req_size == 2'd1 & t_req_addr[0]) |
               (t_req_size == 2'd2 & |t_req_addr[1:0]) | (|t_req_addr[31:ADDR_W]);
  assign sh  = t_mem_data >> {addr[1:0], 3'b000};
  assign ext = size == 2'd0 ? {{24{~uns & sh[7]}}, sh[7:0]} :
               size == 2'd1 ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
  always_ff @(posedge clk or posedge rstf) begin
    if (rstf) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc) state_nx = bad ? RESP : ISSUE;
      ISSUE:   if (i_mem_ready) state_nx = we ? RESP : WAIT_RD;
      WAIT_RD: if (t_mem_valid) state_nx = RESP;
      RESP:    if (i_rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rstf) begin
    if (rstf) begin
      addr  <= '0;
      size  <= '0;
      uns   <= 1'b0;
      we    <= 1'b0;
      wdata <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      if (acc) begin
        addr  <= t_req_addr[ADDR_W-1:0];
        size  <= t_req_size;
        uns   <= t_req_unsigned;
        we    <= t_req_we;
        wdata <= t_req_wdata;
        rdata <= '0;
        err   <= bad;
      end
      if (state == WAIT_RD && t_mem_valid) rdata <= ext;
    end
  end
  always_comb begin
    iss         = state == ISSUE;
    st          = iss & we;
    t_req_ready = live & (state == IDLE);
    i_mem_valid = iss;
    i_mem_we    = st;
    i_mem_addr  = iss ? {addr[ADDR_W-1:2], 2'b00} : '0;
    i_mem_data  = !st ? 32'd0 : size == 2'd0 ? {4{wdata[7:0]}} :
                  size == 2'd1 ? {2{wdata[15:0]}} : wdata;
    i_mem_mask  = !st ? 4'b0000 : size == 2'd0 ? 4'b0001 << addr[1:0] :
                  size == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    i_rsp_valid = state == RESP;
    i_rsp_data  = i_rsp_valid ? rdata : 32'd0;
    i_rsp_err   = i_rsp_valid & err;
  end
endmodule

// File: doc/lsu_dpram_adapter.md
LSU_DPRAM_ADAPTER -- requirements
Module: lsu_dpram_adapter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 15, the byte-address width of the downstream 32-bit byte-addressable dual-port RAM port (8192 words).
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rstf  in  1  reset, asynchronous, active-high.
REQ-004 t_req_valid  in  1  core load/store request valid.
REQ-005 t_req_ready  out  1  request accepted when valid&ready.
REQ-006 t_req_we  in  1  1=store, 0=load.
REQ-007 t_req_addr  in  32  byte address.
REQ-008 t_req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-009 t_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 t_req_wdata  in  32  store data, right-justified.
REQ-011 i_rsp_valid / i_rsp_ready  out/in  1/1  response handshake to core.
REQ-012 i_rsp_data  out  32  extended load data; 0 for stores and errors.
REQ-013 i_rsp_err  out  1  misaligned, illegal size or out-of-range address.
REQ-014 i_mem_valid / i_mem_ready  out/in  1/1  RAM port request handshake.
REQ-015 i_mem_we  out  1; i_mem_addr  out  ADDR_W; i_mem_data  out  32; i_mem_mask  out  4  RAM port command.
REQ-016 t_mem_valid  in  1; t_mem_data  in  32  RAM read return, no backpressure, one cycle after accepted read.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT_RD, RESP; t_req_ready=1 only in IDLE.
REQ-018 On accept, addr, size, unsigned, we and wdata SHALL be registered; inputs are don't-care afterwards.
REQ-019 Error at accept: size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:ADDR_W]!=0 -> go to RESP with i_rsp_err=1, data 0, no RAM access.
REQ-020 Otherwise IDLE->ISSUE; i_mem_valid=1 from the cycle after accept, held with stable command until i_mem_ready.
REQ-021 i_mem_addr SHALL be {addr[ADDR_W-1:2],2'b00}.
REQ-022 Store lanes: byte replicates wdata[7:0] to all four lanes, mask=1<<addr[1:0]; half replicates wdata[15:0] to both halves, mask 0011 (addr[1]=0) or 1100; word passes wdata, mask 1111.
REQ-023 Loads SHALL drive mask 0000 and we=0.
REQ-024 ISSUE accepted store -> RESP (data 0, err 0); accepted load -> WAIT_RD.
REQ-025 In WAIT_RD, t_mem_valid SHALL capture t_mem_data>>(8*addr[1:0]), truncated to size, sign- or zero-extended per unsigned, into i_rsp_data, and go to RESP.
REQ-026 t_mem_valid outside WAIT_RD SHALL be ignored.
REQ-027 In RESP, i_rsp_valid=1 with stable data/err until i_rsp_ready, then IDLE; next request accepted no earlier than the following cycle.
REQ-028 Best-case load latency: accept N, i_mem_valid N+1, t_mem_valid N+2, i_rsp_valid N+3; store: i_rsp_valid N+2.
REQ-029 One transaction outstanding at most; no reordering.

Reset
REQ-030 While rstf=1, state SHALL be IDLE and t_req_ready=0, i_rsp_valid=0, i_rsp_data=0, i_rsp_err=0, i_mem_valid=0, i_mem_we=0, i_mem_addr=0, i_mem_data=0, i_mem_mask=0, asynchronously.
REQ-031 t_req_ready SHALL rise the first cycle after rstf deasserts.
REQ-032 Reset mid-transaction SHALL abandon it; a t_mem_valid arriving after reset SHALL be ignored.

Verification
REQ-033 Store byte addr=0x0000_0006 wdata=0x0000_00AB, mem_ready=1 -> i_mem_addr=0x0004, i_mem_data=0xABABABAB, mask=0100, rsp err=0 at N+2.
REQ-034 Load half signed addr=0x0002, t_mem_data=0x8001_1234 -> i_rsp_data=0xFFFF_8001; unsigned -> 0x0000_8001.
REQ-035 Load word addr=0x0001 -> i_rsp_err=1, data 0, i_mem_valid never asserted; same for size=11 and addr=0x0001_0000 with ADDR_W=15.
REQ-036 Store word with i_mem_ready low 3 cycles -> i_mem_valid and command stable 4 cycles, single accept, one response.
REQ-037 i_rsp_ready low 5 cycles -> i_rsp_valid/data stable, t_req_ready=0 throughout; stray t_mem_valid in IDLE -> no response.
REQ-038 rstf pulsed in WAIT_RD, t_mem_valid next cycle -> all outputs 0, no i_rsp_valid, next load completes normally.
